// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//
// Registered N-to-2^N line decoder for digit/row strobing. It has two modes:
//   - direct mode: the decoded line follows an index that is changed only by
//     load.
//   - scan mode: the index steps automatically, holding each line for DWELL
//     cycles.
// Every output is taken straight from a flop, so no combinational path runs
// from any input to any output.
//
// Parameters
//   SEL_W      select width, 1..6; the number of lines is NOUT = 2**SEL_W
//   DWELL      cycles each line stays active in scan mode (>= 1)
//   ACTIVE_LOW 1: the selected line is 0 and the others are 1
//              0: one-hot high
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en_n   active-low enable; when high, all lines go inactive at the next edge
//   mode   0 = direct (decode idx), 1 = scan (auto-step)
//   load   single-cycle strobe, idx <= sel (takes effect in both modes)
//   sel    index to load
//   W      decoded lines, NOUT bits, polarity set by ACTIVE_LOW
//   idx    current index register
//   wrap   single-cycle pulse when the scan steps from NOUT-1 back to 0
// -----------------------------------------------------------------------------
module scan_decoder #(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_n,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   W,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int NOUT  = 2 ** SEL_W;
  // The dwell counter is at least one bit wide, so DWELL = 1 still has a
  // legal (always-zero) counter.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(NOUT - 1);
  localparam logic [NOUT-1:0]  W_IDLE  = {NOUT{ACTIVE_LOW}};

  logic [SEL_W-1:0] idx_reg,  idx_next;
  logic [CNT_W-1:0] cnt_reg,  cnt_next;
  logic [NOUT-1:0]  w_reg,    w_next;
  logic             wrap_reg, wrap_next;
  logic [NOUT-1:0]  onehot_next;

  // ---------------------------------------------------------------------------
  // Index / dwell next-state. Priority order: load, then disable-hold, then
  // scan step, then direct mode.
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_next  = idx_reg;
    cnt_next  = cnt_reg;
    wrap_next = 1'b0;

    if (load) begin
      // A load restarts the dwell, so the loaded line gets a full period.
      idx_next = sel;
      cnt_next = '0;
    end else if (en_n) begin
      // Disabled: freeze the index and the count so the scan resumes where it
      // stopped.
      idx_next = idx_reg;
      cnt_next = cnt_reg;
    end else if (mode) begin
      if (cnt_reg == CNT_MAX) begin
        cnt_next  = '0;
        // The natural SEL_W-bit overflow gives the modulo-NOUT wrap.
        idx_next  = idx_reg + SEL_W'(1);
        wrap_next = (idx_reg == IDX_MAX);
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else begin
      // Direct mode keeps the count at zero. Switching into scan mode
      // therefore always starts with a full dwell on the current line.
      cnt_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode the index the register is about to take, so the line change appears
  // on the same edge that changes idx.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NOUT; gi++) begin : g_dec
      assign onehot_next[gi] = (idx_next == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    w_next = W_IDLE;
    if (!en_n) begin
      w_next = ACTIVE_LOW ? ~onehot_next : onehot_next;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg  <= '0;
      cnt_reg  <= '0;
      w_reg    <= W_IDLE;
      wrap_reg <= 1'b0;
    end else begin
      idx_reg  <= idx_next;
      cnt_reg  <= cnt_next;
      w_reg    <= w_next;
      wrap_reg <= wrap_next;
    end
  end

  assign W    = w_reg;
  assign idx  = idx_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//
// Scoreboard bench for scan_decoder. It builds two instances:
//   - dut : SEL_W=2, DWELL=4, ACTIVE_LOW=1
//   - dut2: SEL_W=3, DWELL=1, ACTIVE_LOW=0
// The stimulus tasks drive one cycle each and push the expected post-edge
// outputs into a queue. The monitors pop the queue and compare on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en_n, mode, load;
  logic [1:0] sel;
  logic [3:0] w;
  logic [1:0] idx;
  logic       wrap;

  logic       en2_n, mode2, load2;
  logic [2:0] sel2;
  logic [7:0] w2;
  logic [2:0] idx2;
  logic       wrap2;

  scan_decoder #(.SEL_W(2), .DWELL(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .load(load),
    .sel(sel), .W(w), .idx(idx), .wrap(wrap)
  );

  scan_decoder #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en_n(en2_n), .mode(mode2), .load(load2),
    .sel(sel2), .W(w2), .idx(idx2), .wrap(wrap2)
  );

  typedef struct {
    string      name;
    logic [7:0] w;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m1, m2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Active-low line patterns for the 4-line instance, written out by hand.
  function automatic logic [3:0] wl(input int i);
    case (i)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic step1(input logic e_n, input logic m, input logic ld, input logic [1:0] s,
                       input logic [3:0] ew, input logic [1:0] ei, input logic ewr,
                       input string nm);
    exp_t e;
    @(negedge clk);
    en_n = e_n; mode = m; load = ld; sel = s;
    @(posedge clk);
    #1;
    e.name = nm; e.w = {4'b0000, ew}; e.idx = {1'b0, ei}; e.wrap = ewr;
    q1.push_back(e);
  endtask

  task automatic step2(input logic e_n, input logic m, input logic ld, input logic [2:0] s,
                       input logic [7:0] ew, input logic [2:0] ei, input logic ewr,
                       input string nm);
    exp_t e;
    @(negedge clk);
    en2_n = e_n; mode2 = m; load2 = ld; sel2 = s;
    @(posedge clk);
    #1;
    e.name = nm; e.w = ew; e.idx = ei; e.wrap = ewr;
    q2.push_back(e);
  endtask

  // Monitors: one transaction per popped entry.
  always @(negedge clk) begin
    if (q1.size() > 0) begin
      m1 = q1.pop_front();
      $display("%0t dut  %s: W=%b idx=%0d wrap=%b", $time, m1.name, w, idx, wrap);
      chk({m1.name, " W"},    32'(w),    32'(m1.w[3:0]));
      chk({m1.name, " idx"},  32'(idx),  32'(m1.idx[1:0]));
      chk({m1.name, " wrap"}, 32'(wrap), 32'(m1.wrap));
    end
  end

  always @(negedge clk) begin
    if (q2.size() > 0) begin
      m2 = q2.pop_front();
      $display("%0t dut2 %s: W=%h idx=%0d wrap=%b", $time, m2.name, w2, idx2, wrap2);
      chk({m2.name, " W2"},    32'(w2),    32'(m2.w));
      chk({m2.name, " idx2"},  32'(idx2),  32'(m2.idx));
      chk({m2.name, " wrap2"}, 32'(wrap2), 32'(m2.wrap));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en_n = 1'b1; mode = 1'b0; load = 1'b0; sel = 2'd0;
    en2_n = 1'b1; mode2 = 1'b0; load2 = 1'b0; sel2 = 3'd0;
    #12;
    chk("reset W",     32'(w),     32'hF);
    chk("reset idx",   32'(idx),   32'd0);
    chk("reset wrap",  32'(wrap),  32'd0);
    chk("reset W2",    32'(w2),    32'h00);
    chk("reset idx2",  32'(idx2),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct mode: each load shows one cycle later, then holds.
    for (int s = 0; s < 4; s++) begin
      step1(1'b0, 1'b0, 1'b1, 2'(s), wl(s), 2'(s), 1'b0, "direct load");
      step1(1'b0, 1'b0, 1'b0, 2'd0, wl(s), 2'(s), 1'b0, "direct hold");
    end

    // Enable: outputs go idle, idx holds, load still works while disabled.
    step1(1'b0, 1'b0, 1'b1, 2'd2, wl(2), 2'd2, 1'b0, "en load");
    step1(1'b1, 1'b0, 1'b0, 2'd0, 4'hF,  2'd2, 1'b0, "en off");
    step1(1'b1, 1'b0, 1'b0, 2'd0, 4'hF,  2'd2, 1'b0, "en off hold");
    step1(1'b1, 1'b0, 1'b1, 2'd1, 4'hF,  2'd1, 1'b0, "load while off");
    step1(1'b1, 1'b0, 1'b1, 2'd2, 4'hF,  2'd2, 1'b0, "load while off");
    step1(1'b0, 1'b0, 1'b0, 2'd0, wl(2), 2'd2, 1'b0, "en on");

    // Scan from idx 0: 4 cycles per line, wrap on the 16th step.
    step1(1'b0, 1'b0, 1'b1, 2'd0, wl(0), 2'd0, 1'b0, "scan prep");
    for (int t = 1; t <= 22; t++)
      step1(1'b0, 1'b1, 1'b0, 2'd0, wl((t / 4) % 4), 2'((t / 4) % 4), (t % 16 == 0), "scan");

    // At this point idx=1, cnt=2: a load of 3 restarts the dwell on line 3.
    step1(1'b0, 1'b1, 1'b1, 2'd3, wl(3), 2'd3, 1'b0, "scan load");
    for (int k = 1; k <= 13; k++)
      step1(1'b0, 1'b1, 1'b0, 2'd0, wl((3 + k / 4) % 4), 2'((3 + k / 4) % 4), (k == 4),
            "post load");

    // Asynchronous reset mid-scan (idx=2): outputs clear with no clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst W",    32'(w),    32'hF);
    chk("async rst idx",  32'(idx),  32'd0);
    chk("async rst wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Leaving scan mode clears the count; re-entry gives a full dwell.
    step1(1'b0, 1'b1, 1'b0, 2'd0, wl(0), 2'd0, 1'b0, "mode sw a");
    step1(1'b0, 1'b1, 1'b0, 2'd0, wl(0), 2'd0, 1'b0, "mode sw b");
    step1(1'b0, 1'b0, 1'b0, 2'd0, wl(0), 2'd0, 1'b0, "mode 1->0");
    for (int t = 1; t <= 4; t++)
      step1(1'b0, 1'b1, 1'b0, 2'd0, wl(t / 4), 2'(t / 4), 1'b0, "mode 0->1");

    // Disabled scan: no stepping, idle outputs.
    for (int t = 0; t < 3; t++)
      step1(1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 2'd1, 1'b0, "scan disabled");
    for (int t = 1; t <= 4; t++)
      step1(1'b0, 1'b1, 1'b0, 2'd0, wl(1 + t / 4), 2'(1 + t / 4), 1'b0, "scan resume");

    // dut2: DWELL=1, active-high one-hot walking every cycle, wrap every 8.
    step2(1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b0, "walk load");
    for (int t = 1; t <= 17; t++)
      step2(1'b0, 1'b1, 1'b0, 3'd0, 8'(1 << (t % 8)), 3'(t % 8), (t % 8 == 0), "walk");

    @(negedge clk);
    @(negedge clk);
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q1.size(), q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
